// File: rtl/uart_pkg.sv
// uart_pkg -- shared UART definitions.
// Contents: data width, oversampling ratio, receiver state enum, and the
// baud divisor function used by the receiver and transmitter tick dividers.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state).
package uart_pkg;

  localparam int DATA_W     = 8;
  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } rx_state_t;

  // Rounded divisor: round(clk_freq / (baud * os)).
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    return (clk_freq + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_rx_frontend_if.sv
// uart_rx_frontend_if -- byte handshake and status bundle of the receiver.
// master: receiver side (drives rx_data, rx_valid, frame_err, parity_err,
//         overrun, busy; samples rx_ready).
// slave : consumer side (samples data/status; drives rx_ready).
interface uart_rx_frontend_if;
  import uart_pkg::*;

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              frame_err;
  logic              parity_err;
  logic              overrun;
  logic              busy;

  modport master (
    output rx_data, rx_valid, frame_err, parity_err, overrun, busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, parity_err, overrun, busy,
    output rx_ready
  );
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick -- free-running divider producing a one-clock tick every
// DIV clocks (counter 0..DIV-1, tick at DIV-1).
// Ports: clk, reset (sync, active-low), tick (output pulse).
module uart_baud_tick #(
  parameter int DIV = 78
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend -- UART receive front end (8N1, or 8E1 with
// UART_RX_PARITY_EN defined).
// Ports:
//   clk    system clock
//   reset  synchronous, active-low reset
//   rx     asynchronous serial line, idle high
//   bus    uart_rx_frontend_if.master: rx_data/rx_valid/rx_ready handshake,
//          frame_err/parity_err/overrun one-clock pulses, busy.
// Macro: UART_RX_PARITY_EN enables the even-parity bit; undefined ties
// parity_err to 0.
module uart_rx_frontend #(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx,
  uart_rx_frontend_if.master       bus
);
  import uart_pkg::*;

  localparam int          DIV  = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam logic [3:0]  MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]  LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0]  MSB  = 3'(DATA_W - 1);

  logic              rx_p0, rx_p1;
  logic              rx_s;
  logic              tick;
  rx_state_t         state, state_nxt;
  logic [3:0]        tcnt, tcnt_nxt;
  logic [2:0]        bit_idx, bit_nxt;
  logic [DATA_W-1:0] shreg;
  logic              sample_en;
  logic              deliver;
  logic              ferr_set;
  logic              accept;
  logic              perr_now;
`ifdef UART_RX_PARITY_EN
  logic              perr_pend, perr_nxt;
`endif

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Stage p0/p1: two-flop synchroniser on the raw line
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end
  assign rx_s = rx_p1;

  // FSM next-state: tcnt counts ticks within the current bit; after the
  // mid-start sample it is cleared so LAST lands mid-bit on every later bit.
  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    bit_nxt   = bit_idx;
    sample_en = 1'b0;
    deliver   = 1'b0;
    ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_nxt  = perr_pend;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          tcnt_nxt  = '0;
`ifdef UART_RX_PARITY_EN
          perr_nxt  = 1'b0;
`endif
        end
      end
      START: begin
        if (tick) begin
          if (tcnt == MID) begin
            if (rx_s) begin
              state_nxt = IDLE;  // glitch, silently ignored
            end else begin
              state_nxt = DATA;
              bit_nxt   = '0;
              tcnt_nxt  = '0;
            end
          end else begin
            tcnt_nxt = tcnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tcnt == LAST) begin
            sample_en = 1'b1;
            tcnt_nxt  = '0;
            if (bit_idx == MSB) begin
`ifdef UART_RX_PARITY_EN
              state_nxt = PARITY;
`else
              state_nxt = STOP;
`endif
            end else begin
              bit_nxt = bit_idx + 1'b1;
            end
          end else begin
            tcnt_nxt = tcnt + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (tcnt == LAST) begin
            perr_nxt  = rx_s ^ (^shreg);
            tcnt_nxt  = '0;
            state_nxt = STOP;
          end else begin
            tcnt_nxt = tcnt + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (tcnt == LAST) begin
            if (rx_s) begin
              deliver   = 1'b1;
              state_nxt = IDLE;
            end else begin
              ferr_set  = 1'b1;
              state_nxt = BREAK;
            end
          end else begin
            tcnt_nxt = tcnt + 1'b1;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      tcnt    <= '0;
      bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
      perr_pend <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      tcnt    <= tcnt_nxt;
      bit_idx <= bit_nxt;
`ifdef UART_RX_PARITY_EN
      perr_pend <= perr_nxt;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (sample_en) shreg[bit_idx] <= rx_s;
  end

`ifdef UART_RX_PARITY_EN
  assign perr_now = deliver & perr_pend;
`else
  assign perr_now = 1'b0;
`endif

  assign accept = bus.rx_valid & bus.rx_ready;

  // Stage p2: output register; a delivery landing while the old byte is
  // still pending (and not taken this cycle) is dropped as an overrun.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.rx_data    <= '0;
      bus.rx_valid   <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      bus.frame_err  <= ferr_set;
      bus.parity_err <= perr_now;
      bus.overrun    <= deliver & bus.rx_valid & ~accept;
      if (deliver && (!bus.rx_valid || accept)) begin
        bus.rx_data  <= shreg;
        bus.rx_valid <= 1'b1;
      end else if (accept) begin
        bus.rx_valid <= 1'b0;
      end
    end
  end

  assign bus.busy = (state != IDLE) && (state != BREAK);

endmodule

// File: tb/tb_uart_rx_frontend.sv
`timescale 1ns/1ps
module tb_uart_rx_frontend;
  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int DIV      = 10;
  localparam int BIT      = 16 * DIV;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic rx    = 1'b1;

  uart_rx_frontend_if bus();

  uart_rx_frontend #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Event monitor, sampled on the falling edge.
  int         n_valid = 0;
  int         n_ferr  = 0;
  int         n_perr  = 0;
  int         n_ovr   = 0;
  int         n_busy  = 0;
  logic       valid_q = 1'b0;
  logic [7:0] last_data = 8'h00;

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1 && valid_q !== 1'b1) begin
      n_valid++;
      last_data = bus.rx_data;
    end
    valid_q = bus.rx_valid;
    if (bus.frame_err === 1'b1)  n_ferr++;
    if (bus.parity_err === 1'b1) n_perr++;
    if (bus.overrun === 1'b1)    n_ovr++;
    if (bus.busy === 1'b1)       n_busy++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_bit, input logic stop_bit);
    rx = 1'b0;
    step(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(BIT);
    end
    if (PAR) begin
      rx = par_bit;
      step(BIT);
    end
    rx = stop_bit;
    step(BIT);
  endtask

  task automatic test_reset();
    int v0, f0, b0;
    reset = 1'b0;
    bus.rx_ready = 1'b1;
    step(2);
    n_cmp++; if (bus.rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", bus.rx_data); end
    n_cmp++; if (bus.rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.rx_valid); end
    n_cmp++; if (bus.frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b want 0", bus.frame_err); end
    n_cmp++; if (bus.parity_err !== 1'b0) begin n_bad++; $display("FAIL reset_perr: got %b want 0", bus.parity_err); end
    n_cmp++; if (bus.overrun !== 1'b0) begin n_bad++; $display("FAIL reset_ovr: got %b want 0", bus.overrun); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    reset = 1'b1;
    v0 = n_valid; f0 = n_ferr; b0 = n_busy;
    step(20000);
    n_cmp++; if (n_busy - b0 !== 0) begin n_bad++; $display("FAIL idle_busy: got %0d busy cycles want 0", n_busy - b0); end
    n_cmp++; if (n_valid - v0 !== 0) begin n_bad++; $display("FAIL idle_valid: got %0d pulses want 0", n_valid - v0); end
    n_cmp++; if (n_ferr - f0 !== 0) begin n_bad++; $display("FAIL idle_ferr: got %0d pulses want 0", n_ferr - f0); end
  endtask

  task automatic test_basic();
    int v0, f0, o0, p0;
    bus.rx_ready = 1'b1;
    v0 = n_valid; f0 = n_ferr; o0 = n_ovr; p0 = n_perr;
    send_frame(8'h64, 1'b1, 1'b1);
    step(20);
    n_cmp++; if (n_valid - v0 !== 1) begin n_bad++; $display("FAIL basic_valid_cnt: got %0d want 1", n_valid - v0); end
    n_cmp++; if (last_data !== 8'h64) begin n_bad++; $display("FAIL basic_data: got %h want 64", last_data); end
    n_cmp++; if (bus.rx_valid !== 1'b0) begin n_bad++; $display("FAIL basic_drained: got %b want 0", bus.rx_valid); end
    n_cmp++; if ((n_ferr - f0) + (n_ovr - o0) + (n_perr - p0) !== 0) begin n_bad++; $display("FAIL basic_errs: got %0d error pulses want 0", (n_ferr - f0) + (n_ovr - o0) + (n_perr - p0)); end
    step(120);
    send_frame(8'h66, 1'b0, 1'b1);
    step(20);
    n_cmp++; if (n_valid - v0 !== 2) begin n_bad++; $display("FAIL basic2_valid_cnt: got %0d want 2", n_valid - v0); end
    n_cmp++; if (last_data !== 8'h66) begin n_bad++; $display("FAIL basic2_data: got %h want 66", last_data); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL basic2_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_glitch();
    int v0, f0, b0;
    v0 = n_valid; f0 = n_ferr; b0 = n_busy;
    rx = 1'b0;
    step(4);
    rx = 1'b1;
    step(2 * BIT);
    n_cmp++; if (n_valid - v0 !== 0) begin n_bad++; $display("FAIL glitch_valid: got %0d want 0", n_valid - v0); end
    n_cmp++; if (n_ferr - f0 !== 0) begin n_bad++; $display("FAIL glitch_ferr: got %0d want 0", n_ferr - f0); end
    n_cmp++; if ((n_busy - b0) < 7 * DIV || (n_busy - b0) > 8 * DIV + 2) begin n_bad++; $display("FAIL glitch_busy_len: got %0d cycles want %0d..%0d", n_busy - b0, 7 * DIV, 8 * DIV + 2); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_end: got %b want 0", bus.busy); end
  endtask

  task automatic test_frame_err();
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h55, 1'b0, 1'b0);
    step(5 * BIT);
    rx = 1'b1;
    step(BIT);
    n_cmp++; if (n_ferr - f0 !== 1) begin n_bad++; $display("FAIL ferr_count: got %0d want 1", n_ferr - f0); end
    n_cmp++; if (n_valid - v0 !== 0) begin n_bad++; $display("FAIL ferr_novalid: got %0d want 0", n_valid - v0); end
    send_frame(8'hA3, 1'b0, 1'b1);
    step(20);
    n_cmp++; if (n_valid - v0 !== 1) begin n_bad++; $display("FAIL ferr_next_cnt: got %0d want 1", n_valid - v0); end
    n_cmp++; if (last_data !== 8'hA3) begin n_bad++; $display("FAIL ferr_next_data: got %h want a3", last_data); end
    n_cmp++; if (n_ferr - f0 !== 1) begin n_bad++; $display("FAIL ferr_total: got %0d want 1", n_ferr - f0); end
  endtask

  task automatic test_overrun();
    int v0, o0;
    bus.rx_ready = 1'b0;
    v0 = n_valid; o0 = n_ovr;
    send_frame(8'h11, 1'b0, 1'b1);
    step(20);
    n_cmp++; if (bus.rx_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_held: got %b want 1", bus.rx_valid); end
    n_cmp++; if (bus.rx_data !== 8'h11) begin n_bad++; $display("FAIL ovr_first: got %h want 11", bus.rx_data); end
    send_frame(8'h22, 1'b0, 1'b1);
    step(20);
    n_cmp++; if (n_ovr - o0 !== 1) begin n_bad++; $display("FAIL ovr_count: got %0d want 1", n_ovr - o0); end
    n_cmp++; if (bus.rx_data !== 8'h11) begin n_bad++; $display("FAIL ovr_kept: got %h want 11", bus.rx_data); end
    n_cmp++; if (n_valid - v0 !== 1) begin n_bad++; $display("FAIL ovr_valid_cnt: got %0d want 1", n_valid - v0); end
    bus.rx_ready = 1'b1;
    step(1);
    n_cmp++; if (bus.rx_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_drain: got %b want 0", bus.rx_valid); end
  endtask

  task automatic test_parity();
    int p0, v0;
    bus.rx_ready = 1'b1;
    p0 = n_perr; v0 = n_valid;
    // 0x07 has three ones: even parity bit is 1, so 0 is a mismatch.
    send_frame(8'h07, 1'b0, 1'b1);
    step(20);
`ifdef UART_RX_PARITY_EN
    n_cmp++; if (n_perr - p0 !== 1) begin n_bad++; $display("FAIL par_bad_pulse: got %0d want 1", n_perr - p0); end
`else
    n_cmp++; if (n_perr - p0 !== 0) begin n_bad++; $display("FAIL par_off_pulse: got %0d want 0", n_perr - p0); end
`endif
    n_cmp++; if (last_data !== 8'h07) begin n_bad++; $display("FAIL par_bad_data: got %h want 07", last_data); end
    p0 = n_perr;
    send_frame(8'h07, 1'b1, 1'b1);
    step(20);
    n_cmp++; if (n_perr - p0 !== 0) begin n_bad++; $display("FAIL par_good_pulse: got %0d want 0", n_perr - p0); end
    n_cmp++; if (n_valid - v0 !== 2) begin n_bad++; $display("FAIL par_valid_cnt: got %0d want 2", n_valid - v0); end
  endtask

  initial begin
    bus.rx_ready = 1'b1;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_frontend.md
# uart_rx_frontend

Serial receive front end feeding the UART top level. Synchronises the asynchronous `rx` line, generates a 16× oversampling tick from the system clock, recovers 8N1 frames (optional even parity), and presents each byte on a valid/ready handshake to the downstream consumer (command decoder / seven-segment path). Also reports framing, parity and overrun errors.

## Interface
- `CLK_FREQ`, 12000000, system clock in Hz
- `BAUD`, 9600, line rate in bit/s
- `OVERSAMPLE`, 16, ticks per bit; fixed at 16 for this release
- `clk`  input  1  system clock
- `reset`  input  1  synchronous, active-low reset
- `rx`  input  1  asynchronous serial line, idle high
- `rx_ready`  input  1  consumer accepts `rx_data` when high with `rx_valid`
- `rx_data`  output  8  received byte, LSB first on the line
- `rx_valid`  output  1  byte available; held until accepted
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low
- `parity_err`  output  1  one-cycle pulse: parity mismatch (0 when parity compiled out)
- `overrun`  output  1  one-cycle pulse: byte completed while `rx_valid` still high
- `busy`  output  1  high from start-bit detect to end of stop bit

## Operation
- Reset is sampled on `clk` when `reset`=0. Reset values: `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, `busy`=0, synchroniser flops=1, state=IDLE, tick divider=0, tick counter=0.
- `rx` passes through a 2-flop synchroniser before any use.
- Tick divider: DIV = round(CLK_FREQ/(BAUD*OVERSAMPLE)) = 78 at defaults; counter 0..DIV-1, `tick` asserted for one clock at DIV-1, then wraps to 0. The divider free-runs and is never restarted by frame activity.
- States: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
- IDLE: synchronised `rx`=0 → START, tick counter cleared, `busy`=1.
- START: on the 8th tick (count 7, mid-bit) sample; 1 → glitch, back to IDLE with no error pulse; 0 → DATA, bit index 0, tick counter cleared.
- DATA: every 16th tick sample into shift register at `bit index`; after bit 7 → PARITY (if enabled) else STOP.
- PARITY: sample at mid-bit; mismatch against even parity of data latches a pending parity error.
- STOP: sample at mid-bit. 1 → deliver byte, back to IDLE. 0 → `frame_err` pulse, byte discarded, → BREAK.
- BREAK: wait for synchronised `rx`=1, then IDLE. A continuous low line produces exactly one `frame_err`.
- Delivery: if `rx_valid`=0, load `rx_data`, set `rx_valid`. If `rx_valid`=1 and not accepted in that same cycle, new byte dropped, `overrun` pulses, old byte kept. Same-cycle accept and delivery: new byte loaded, `rx_valid` stays 1, no overrun.
- `parity_err` pulses in the delivery cycle; the byte is still delivered.
- Handshake: transfer when `rx_valid`&&`rx_ready` on a rising edge; `rx_valid` drops next cycle unless a new byte lands simultaneously. `rx_ready` may be held high permanently.

## Timing
- Bit time at defaults = 16×78 = 1248 clocks (104.0 µs at 12 MHz); tolerates ±3% line-rate mismatch.
- Start detect latency: 2 clocks (synchroniser) + up to 1 clock.
- `rx_valid` rises 1 clock after the stop-bit mid-sample tick; `busy` falls in that same cycle.
- Error pulses are exactly one clock wide and coincide with the cycle `rx_valid` would rise.
- Reset mid-frame: frame abandoned, no outputs asserted; re-arm requires a fresh falling edge.

## Configuration
- `UART_RX_PARITY_EN` defined: frame is 8E1; PARITY state present; `parity_err` active.
- Undefined: frame is 8N1; PARITY state and parity logic removed; `parity_err` tied 0.

## Structure
- Shared package `uart_pkg`: state enum, `OVERSAMPLE` constant, divisor-compute function, data width constant (8).
- One sub-module: `uart_baud_tick` (parameterised divider producing `tick`); reused by the transmitter.

## Test plan
- Reset low 2 cycles, line idle → all outputs 0, `busy`=0 for 20000 clocks.
- Send 0x64 at 9600 baud, `rx_ready`=1 → single `rx_valid` pulse with `rx_data`=0x64, no error pulses; then 0x66 after 10 µs gap → `rx_data`=0x66.
- 300 ns low glitch on idle line → no `busy` beyond START, no `rx_valid`, no `frame_err`.
- Send 0x55 with stop bit forced low, then hold line low 5 bit times → exactly one `frame_err`, no `rx_valid`; next good byte 0xA3 received correctly.
- `rx_ready`=0, send 0x11 then 0x22 → `rx_data` stays 0x11, one `overrun` pulse; raising `rx_ready` drains 0x11 and `rx_valid` falls.
- With `UART_RX_PARITY_EN`: 0x07 with parity bit 0 → `parity_err` pulse and `rx_data`=0x07; with parity 1 → no error.
